// File: rtl/lmac_arb_pkg.sv
// Shared constants, state encoding and helpers for the LMAC RX port arbiter.
package lmac_arb_pkg;

    localparam int CTRL_SOF = 0;
    localparam int CTRL_EOF = 1;
    localparam int CTRL_ERR = 2;

    // Terminating beat for an aborted packet: pkt_end + err.
    localparam logic [7:0] ABORT_CTRL = 8'h06;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        ABORT
    } arb_state_t;

    // Port index 'off' positions after 'base', wrapping at n (off <= n).
    function automatic int rr_next(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/lmac_rx_port_arb_if.sv
// FWFT ingress channels and merged egress stream of the LMAC RX port arbiter.
interface lmac_rx_port_arb_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int CTRL_W    = 8
);
    localparam int PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]        port_en;
    logic [NUM_PORTS*DATA_W-1:0] ch_data;
    logic [NUM_PORTS*CTRL_W-1:0] ch_ctrl;
    logic [NUM_PORTS-1:0]        ch_empty;
    logic [NUM_PORTS-1:0]        ch_rd;
    logic [DATA_W-1:0]           out_data;
    logic [CTRL_W-1:0]           out_ctrl;
    logic [PORT_W-1:0]           out_port;
    logic                        out_vld;
    logic                        out_rdy;

    modport master (
        output port_en, ch_data, ch_ctrl, ch_empty, out_rdy,
        input  ch_rd, out_data, out_ctrl, out_port, out_vld
    );

    modport slave (
        input  port_en, ch_data, ch_ctrl, ch_empty, out_rdy,
        output ch_rd, out_data, out_ctrl, out_port, out_vld
    );

endinterface

// File: rtl/lmac_arb_skid.sv
// Two-entry valid/ready output buffer; the head entry drives the outputs directly.
module lmac_arb_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_word,
    output logic         in_room,
    output logic         out_vld,
    output logic [W-1:0] out_word,
    input  logic         out_rdy
);
    logic [1:0]   count;
    logic [W-1:0] head;
    logic [W-1:0] spare;
    logic         push;
    logic         pop;

    assign in_room  = (count != 2'd2);
    assign out_vld  = (count != 2'd0);
    assign out_word = head;
    assign push     = in_vld && in_room;
    assign pop      = out_vld && out_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: both entries are reset (not just count) because the outputs must read 0 out of reset.
            count <= 2'd0;
            head  <= '0;
            spare <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge count/head.
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= in_word;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_word;
                    end else if (push) begin
                        spare <= in_word;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head  <= spare;
                        count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/lmac_rx_port_arb.sv
// Packet-granular round-robin merge of NUM_PORTS LMAC RX FIFO streams into one skid-buffered stream.
// Optional per-port packet statistics are enabled by defining LMAC_ARB_PORT_STATS_EN.
module lmac_rx_port_arb
    import lmac_arb_pkg::*;
#(
    parameter int  NUM_PORTS   = 4,
    parameter int  DATA_W      = 64,
    parameter int  CTRL_W      = 8,
    parameter int  TIMEOUT_CYC = 256,
    localparam int PORT_W      = $clog2(NUM_PORTS)
) (
    input  logic              clk,
    input  logic              reset,
    lmac_rx_port_arb_if.slave bus,
    output logic [31:0]       sof_err_cnt,
    output logic [31:0]       abort_cnt
`ifdef LMAC_ARB_PORT_STATS_EN
    ,
    input  logic [PORT_W-1:0] stat_sel,
    output logic [31:0]       stat_pkt_cnt
`endif
);
    localparam int SKID_W = DATA_W + CTRL_W + PORT_W;
    localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit   TMO_EN = (TIMEOUT_CYC != 0);

    arb_state_t           state;
    arb_state_t           next_state;
    logic [PORT_W-1:0]    grant;
    logic [PORT_W-1:0]    rr_ptr;
    logic [PORT_W-1:0]    pick;
    logic                 pick_vld;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [NUM_PORTS-1:0] ch_rd;
    logic                 skid_room;
    logic                 push_vld;
    logic [SKID_W-1:0]    push_word;
    logic [SKID_W-1:0]    skid_out;
    logic                 sof_err_inc;
    logic                 abort_inc;

    logic [DATA_W-1:0] ch_data_a [NUM_PORTS];
    logic [CTRL_W-1:0] ch_ctrl_a [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign ch_data_a[i] = bus.ch_data[i*DATA_W +: DATA_W];
        assign ch_ctrl_a[i] = bus.ch_ctrl[i*CTRL_W +: CTRL_W];
    end

    // First enabled, non-empty port after the round-robin pointer.
    always_comb begin
        logic [PORT_W-1:0] idx;
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = PORT_W'(rr_next(int'(rr_ptr), k, NUM_PORTS));
            if (!pick_vld && bus.port_en[idx] && !bus.ch_empty[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        next_state  = state;
        ch_rd       = '0;
        push_vld    = 1'b0;
        push_word   = '0;
        sof_err_inc = 1'b0;
        abort_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    if (!ch_ctrl_a[pick][CTRL_SOF]) begin
                        ch_rd[pick] = 1'b1;
                        sof_err_inc = 1'b1;
                    end else begin
                        next_state = XFER;
                    end
                end
            end
            XFER: begin
                if (!bus.ch_empty[grant]) begin
                    if (skid_room) begin
                        ch_rd[grant] = 1'b1;
                        push_vld     = 1'b1;
                        push_word    = {ch_data_a[grant], ch_ctrl_a[grant], grant};
                        if (ch_ctrl_a[grant][CTRL_EOF]) next_state = IDLE;
                    end
                end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
                    next_state = ABORT;
                end
            end
            ABORT: begin
                if (skid_room) begin
                    push_vld   = 1'b1;
                    push_word  = {{DATA_W{1'b0}}, CTRL_W'(ABORT_CTRL), grant};
                    abort_inc  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // No pop may leak out while reset is held, even with a bad head beat waiting.
    assign bus.ch_rd = reset ? '0 : ch_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= PORT_W'(NUM_PORTS - 1);
            tmo_cnt     <= '0;
            sof_err_cnt <= '0;
            abort_cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == XFER) begin
                grant  <= pick;
                rr_ptr <= pick;
            end
            // Only an empty granted FIFO ages the packet; output backpressure never does.
            if ((|ch_rd) || state != XFER) begin
                tmo_cnt <= '0;
            end else if (bus.ch_empty[grant]) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (sof_err_inc && sof_err_cnt != 32'hFFFF_FFFF) sof_err_cnt <= sof_err_cnt + 32'd1;
            if (abort_inc && abort_cnt != 32'hFFFF_FFFF) abort_cnt <= abort_cnt + 32'd1;
        end
    end

    lmac_arb_skid #(.W(SKID_W)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (push_vld),
        .in_word  (push_word),
        .in_room  (skid_room),
        .out_vld  (bus.out_vld),
        .out_word (skid_out),
        .out_rdy  (bus.out_rdy)
    );

    assign {bus.out_data, bus.out_ctrl, bus.out_port} = skid_out;

`ifdef LMAC_ARB_PORT_STATS_EN
    logic [31:0] pkt_cnt [NUM_PORTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) pkt_cnt[i] <= '0;
            stat_pkt_cnt <= '0;
        end else begin
            if (bus.out_vld && bus.out_rdy && bus.out_ctrl[CTRL_EOF] && !bus.out_ctrl[CTRL_ERR]) begin
                pkt_cnt[bus.out_port] <= pkt_cnt[bus.out_port] + 32'd1;
            end
            stat_pkt_cnt <= pkt_cnt[stat_sel];
        end
    end
`endif

endmodule
